// File: rtl/jk_seq_ctrl_pkg.sv
// Shared opcode and FSM state definitions for the JK bank sequencer.
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_LOAD   = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Count ops are the only multi-cycle commands.
  function automatic logic is_count(input op_e op);
    return (op == OP_CNT_UP) || (op == OP_CNT_DN);
  endfunction

endpackage

// File: rtl/jk_seq_ctrl_if.sv
// Command / status bundle between the control master and the sequencer.
interface jk_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    input  cmd_ready, q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    output cmd_ready, q, busy, done
  );
endinterface

// File: rtl/jk_seq_ctrl_ff_bank.sv
// Bank of WIDTH independent JK flip-flops, cleared by async active-low reset.
module jk_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Standard JK truth table per bit: hold, reset, set, toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b01:   q_q[i] <= 1'b0;
          2'b10:   q_q[i] <= 1'b1;
          2'b11:   q_q[i] <= ~q_q[i];
          default: q_q[i] <= q_q[i];
        endcase
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer: accepts one command, drives J/K into the bank, pulses done.
module jk_seq_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  jk_seq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] step_q, step_d;

  logic [WIDTH-1:0] j_drv, k_drv;
  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] up_t, dn_t;

  // Toggle enables for binary count: bit i flips when all lower bits are 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign up_t[gi] = up_t[gi-1] &  q_bank[gi-1];
      assign dn_t[gi] = dn_t[gi-1] & ~q_bank[gi-1];
    end
  endgenerate

  // State and latched-command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      step_q  <= step_d;
    end
  end

  // Next-state and J/K drive; J/K stay zero outside RUN so the bank holds.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    step_d  = step_q;
    j_drv   = '0;
    k_drv   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = op_e'(bus.cmd_op);
          data_d = bus.cmd_data;
          step_d = bus.cmd_len;
          // A zero-length count has nothing to do and skips RUN entirely.
          if (is_count(op_e'(bus.cmd_op)) && (bus.cmd_len == '0)) state_d = ST_DONE;
          else                                                    state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (is_count(op_q)) begin
          if (bus.abort) begin
            state_d = ST_DONE;
          end else begin
            j_drv  = (op_q == OP_CNT_UP) ? up_t : dn_t;
            k_drv  = j_drv;
            step_d = step_q - LEN_W'(1);
            if (step_q == LEN_W'(1)) state_d = ST_DONE;
          end
        end else begin
          case (op_q)
            OP_CLEAR:  k_drv = '1;
            OP_SET:    j_drv = '1;
            OP_TOGGLE: begin j_drv = data_q; k_drv = data_q;  end
            OP_LOAD:   begin j_drv = data_q; k_drv = ~data_q; end
            default:   ;
          endcase
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (reset),
    .j     (j_drv),
    .k     (k_drv),
    .q     (q_bank)
  );

  assign bus.q         = q_bank;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Scoreboard bench for jk_seq_ctrl: final q of each command is checked on its done pulse.
module tb_jk_seq_ctrl;
  import jk_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [WIDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  jk_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  jk_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // Each done pulse pops the expected final q for the command that produced it.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else                  chk("done_q", 32'(bus.q), 32'(sb_q.pop_front()));
    end
  end

  // Drive one command; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                      input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] exp_q,
                      input bit push, input bit hold);
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bus.cmd_ready) got = 1;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    if (push) sb_q.push_back(exp_q);
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus.cmd_ready) got = 1;
    end
    if (!got) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                         input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] exp_q);
    send(op, data, len, exp_q, 1'b1, 1'b0);
    wait_idle();
  endtask

  initial begin
    logic [WIDTH-1:0] up_seq [3];
    logic [WIDTH-1:0] dn_seq [2];
    up_seq = '{4'b1111, 4'b0000, 4'b0001};
    dn_seq = '{4'b0000, 4'b1111};
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;

    // Reset state while held low, with a command offered that must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(OP_SET);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // LOAD latency: q at E1, done after E1, ready after E2.
    send(3'(OP_LOAD), 4'b1010, 8'd0, 4'b1010, 1'b1, 1'b0);
    chk("lat_e0_q", 32'(bus.q), 32'd0);
    chk("lat_e0_ready", 32'(bus.cmd_ready), 32'd0);
    chk("lat_e0_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_e1_q", 32'(bus.q), 32'b1010);
    chk("lat_e1_done", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    chk("lat_e2_done", 32'(bus.done), 32'd0);
    chk("lat_e2_ready", 32'(bus.cmd_ready), 32'd1);
    wait_idle();

    // Single-cycle ops.
    run_cmd(3'(OP_TOGGLE), 4'b0110, 8'd0, 4'b1100);
    run_cmd(3'(OP_SET),    4'b0000, 8'd0, 4'b1111);
    run_cmd(3'(OP_CLEAR),  4'b0000, 8'd0, 4'b0000);
    run_cmd(3'(OP_LOAD),   4'b1001, 8'd0, 4'b1001);
    run_cmd(3'(OP_NOP),    4'b0110, 8'd0, 4'b1001);
    run_cmd(3'(OP_RSVD),   4'b0110, 8'd0, 4'b1001);

    // COUNT_UP len=3 from 1110 with wrap.
    run_cmd(3'(OP_LOAD), 4'b1110, 8'd0, 4'b1110);
    send(3'(OP_CNT_UP), 4'b0000, 8'd3, 4'b0001, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk($sformatf("up_step%0d_q", s), 32'(bus.q), 32'(up_seq[s]));
      chk($sformatf("up_step%0d_done", s), 32'(bus.done), (s == 2) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // COUNT_DOWN len=2 from 0001 with wrap.
    run_cmd(3'(OP_LOAD), 4'b0001, 8'd0, 4'b0001);
    send(3'(OP_CNT_DN), 4'b0000, 8'd2, 4'b1111, 1'b1, 1'b0);
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      chk($sformatf("dn_step%0d_q", s), 32'(bus.q), 32'(dn_seq[s]));
    end
    wait_idle();

    // Zero-length count goes straight to DONE.
    send(3'(OP_CNT_UP), 4'b0000, 8'd0, 4'b1111, 1'b1, 1'b0);
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_q", 32'(bus.q), 32'b1111);
    wait_idle();

    // Abort in the 4th RUN cycle, with cmd_valid held and operands changed meanwhile.
    run_cmd(3'(OP_LOAD), 4'b0000, 8'd0, 4'b0000);
    send(3'(OP_CNT_UP), 4'b0000, 8'd10, 4'b0011, 1'b1, 1'b1);
    bus.cmd_op   = 3'(OP_LOAD);
    bus.cmd_data = 4'b1111;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_pre_q", 32'(bus.q), 32'b0011);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_done", 32'(bus.done), 32'd1);
    chk("abort_q", 32'(bus.q), 32'b0011);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_idle_q", 32'(bus.q), 32'b0011);
    wait_idle();

    // Reset mid-count: command lost, no done.
    send(3'(OP_CNT_UP), 4'b0000, 8'd10, 4'b0000, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("mid_rst_q", 32'(bus.q), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    run_cmd(3'(OP_LOAD), 4'b0101, 8'd0, 4'b0101);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
